// File: rtl/uart_tx.sv
// UART transmitter: one async frame per accepted word.
// Frame = start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
// Each bit lasts exactly CLKS_PER_BIT clocks.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, ready high, waiting for i_tx_valid
// ST_START  | driving the start bit (low)
// ST_DATA   | driving shift_q[0], shifting right per bit
// ST_PARITY | driving the accumulated parity bit
// ST_STOP   | driving stop bit(s) (high)
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_txd
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_TC    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   cnt_done;

  assign cnt_done   = (cnt_q == CNT_TC);
  assign o_tx_ready = (state_q == ST_IDLE);
  assign o_txd      = txd_q;

  // State and datapath registers; txd is registered from the next-state decode
  // so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state, bit timing and next line level; parity accumulates from the
  // latched shift register as bits go out, so live input data never affects it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (i_tx_valid) begin
          shift_d = i_tx_data;
          cnt_d   = '0;
          idx_d   = '0;
          par_d   = 1'b0;
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_done) begin
          cnt_d   = '0;
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PAR_EN) begin
              state_d = ST_PARITY;
              txd_d   = par_q ^ shift_q[0] ^ PAR_ODD;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (cnt_done) begin
          cnt_d = '0;
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1 at 4 clk/bit; 7N2 at 2 clk/bit)
// checked cycle by cycle against a frame model built from the framing rules.
module tb_uart_tx;

  localparam int CPB [4] = '{4, 4, 4, 2};
  localparam int DB  [4] = '{8, 8, 8, 7};
  localparam int PAR [4] = '{0, 2, 1, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid;
  logic [3:0] txd;
  logic [3:0] ready;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(valid[0]), .i_tx_data(d0),
    .o_tx_ready(ready[0]), .o_txd(txd[0]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(valid[1]), .i_tx_data(d1),
    .o_tx_ready(ready[1]), .o_txd(txd[1]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o81 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(valid[2]), .i_tx_data(d2),
    .o_tx_ready(ready[2]), .o_txd(txd[2]));
  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_n72 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(valid[3]), .i_tx_data(d3),
    .o_tx_ready(ready[3]), .o_txd(txd[3]));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(int i, logic [7:0] w);
    case (i)
      0:       d0 = w;
      1:       d1 = w;
      2:       d2 = w;
      default: d3 = w[6:0];
    endcase
  endtask

  function automatic int flen(int i);
    return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]) * CPB[i];
  endfunction

  // Line level of bit slot 'pos' in the frame of word w for configuration i.
  function automatic logic exp_bit(int i, logic [7:0] w, int pos);
    int ones;
    ones = 0;
    if (pos == 0) return 1'b0;
    if (pos <= DB[i]) return w[pos-1];
    if (PAR[i] != 0 && pos == DB[i] + 1) begin
      for (int b = 0; b < DB[i]; b++) ones += int'(w[b]);
      if (PAR[i] == 1) return (ones % 2 == 0);
      return (ones % 2 == 1);
    end
    return 1'b1;
  endfunction

  // Offer w at the current negedge, then check every cycle E+1..E+F+1.
  // hold: cycles valid stays high after acceptance; chg: data forced to 0xFF meanwhile;
  // nxt: raise valid with nw during the last stop cycle.
  task automatic frame(int i, logic [7:0] w, int hold, bit chg, bit nxt, logic [7:0] nw);
    int f;
    f = flen(i);
    chk($sformatf("ready_before i%0d", i), 32'(ready[i]), 32'd1);
    valid[i] = 1'b1;
    set_data(i, w);
    @(posedge clk);
    for (int n = 1; n <= f; n++) begin
      @(negedge clk);
      if (n > hold) valid[i] = 1'b0;
      else if (chg) set_data(i, 8'hFF);
      if (nxt && n == f) begin
        valid[i] = 1'b1;
        set_data(i, nw);
      end
      chk($sformatf("txd i%0d w%0h n%0d", i, w, n), 32'(txd[i]),
          32'(exp_bit(i, w, (n - 1) / CPB[i])));
      chk($sformatf("ready_busy i%0d n%0d", i, n), 32'(ready[i]), 32'd0);
    end
    @(negedge clk);
    chk($sformatf("ready_after i%0d", i), 32'(ready[i]), 32'd1);
    chk($sformatf("txd_idle i%0d", i), 32'(txd[i]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    rst_n = 1'b0;
    valid = 4'h0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    #12;
    chk("reset_txd", 32'(txd), 32'hF);
    chk("reset_ready", 32'(ready), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(ready), 32'hF);
    chk("idle_txd", 32'(txd), 32'hF);

    // directed frames
    frame(0, 8'h55, 0, 1'b0, 1'b0, 8'h00);
    frame(1, 8'h03, 0, 1'b0, 1'b0, 8'h00);
    frame(2, 8'h03, 0, 1'b0, 1'b0, 8'h00);
    frame(1, 8'h07, 0, 1'b0, 1'b0, 8'h00);
    frame(2, 8'h07, 0, 1'b0, 1'b0, 8'h00);
    frame(3, 8'h5A, 0, 1'b0, 1'b0, 8'h00);

    // held valid with changing data: one frame of 0xA5 only
    frame(0, 8'hA5, 3, 1'b1, 1'b0, 8'h00);
    repeat (3) begin
      @(negedge clk);
      chk("no_double_ready", 32'(ready[0]), 32'd1);
      chk("no_double_txd", 32'(txd[0]), 32'd1);
    end

    // back-to-back, valid raised in the last stop cycle
    frame(0, 8'h01, 0, 1'b0, 1'b1, 8'h80);
    frame(0, 8'h80, 0, 1'b0, 1'b0, 8'h00);
    frame(3, 8'h11, 0, 1'b0, 1'b1, 8'h6E);
    frame(3, 8'h6E, 0, 1'b0, 1'b0, 8'h00);

    // randomized words on every configuration
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        w = 8'($urandom_range(0, (DB[i] == 8) ? 255 : 127));
        frame(i, w, 0, 1'b0, 1'b0, 8'h00);
      end
    end

    // reset in the middle of data bit 3 of 0xF0 (that bit is 0 on the line)
    valid[0] = 1'b1;
    set_data(0, 8'hF0);
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      valid[0] = 1'b0;
    end
    chk("pre_reset_txd", 32'(txd[0]), 32'd0);
    chk("pre_reset_ready", 32'(ready[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_txd", 32'(txd[0]), 32'd1);
    chk("async_reset_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_ready", 32'(ready[0]), 32'd1);
    chk("post_reset_txd", 32'(txd[0]), 32'd1);
    frame(0, 8'h3C, 0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
